// File: rtl/rf_wb_arb_if.sv
// Writeback bus for rf_wb_arb: ALU/LSU request channels, issue/scoreboard
// ports and the registered register-file write port.
interface rf_wb_arb_if;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic        lsu_valid;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        lsu_ready;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        hazard1;
   logic        hazard2;
   logic        write_e;
   logic [4:0]  rd;
   logic [31:0] write_d;

   modport master (
      output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
             issue_valid, issue_rd, rs1, rs2,
      input  alu_ready, lsu_ready, hazard1, hazard2, write_e, rd, write_d
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
             issue_valid, issue_rd, rs1, rs2,
      output alu_ready, lsu_ready, hazard1, hazard2, write_e, rd, write_d
   );
endinterface

// File: rtl/rf_wb_arb.sv
// Register-file writeback arbiter (ALU vs LSU) with a pending-write scoreboard.
// Define RR_ARB_EN for round-robin arbitration; otherwise LSU has fixed priority.
module rf_wb_arb (
   input logic        clk,
   input logic        rst,
   rf_wb_arb_if.slave bus
);
   // Handshake: a transfer happens when valid && ready; the requester holds
   // valid/rd/data until then. ready is a pure function of valid, rst and the
   // arbitration state, never of ready itself.
   logic        alu_gnt;
   logic        lsu_gnt;
   logic        accept;
   logic [4:0]  sel_rd;
   logic [31:0] sel_data;
   logic [31:0] busy_q;
   logic [31:0] busy_d;
   logic        write_e_q;
   logic [4:0]  rd_q;
   logic [31:0] write_d_q;

`ifdef RR_ARB_EN
   typedef enum logic {LAST_ALU = 1'b0, LAST_LSU = 1'b1} last_e;
   last_e last_q;
   last_e last_d;

   always_ff @(posedge clk) begin
      if (rst) last_q <= LAST_LSU;
      else     last_q <= last_d;
   end

   always_comb begin
      alu_gnt = 1'b0;
      lsu_gnt = 1'b0;
      last_d  = last_q;
      if (!rst) begin
         if (bus.alu_valid && bus.lsu_valid) begin
            alu_gnt = (last_q == LAST_LSU);
            lsu_gnt = (last_q == LAST_ALU);
         end else begin
            alu_gnt = bus.alu_valid;
            lsu_gnt = bus.lsu_valid;
         end
         if (alu_gnt)      last_d = LAST_ALU;
         else if (lsu_gnt) last_d = LAST_LSU;
      end
   end
`else
   always_comb begin
      lsu_gnt = !rst && bus.lsu_valid;
      alu_gnt = !rst && bus.alu_valid && !bus.lsu_valid;
   end
`endif

   always_comb begin
      accept   = alu_gnt || lsu_gnt;
      sel_rd   = lsu_gnt ? bus.lsu_rd : bus.alu_rd;
      sel_data = lsu_gnt ? bus.lsu_data : bus.alu_data;
      busy_d   = busy_q;
      if (accept && sel_rd != 5'd0) busy_d[sel_rd] = 1'b0;
      // Set after clear so a same-cycle issue to the same index keeps it busy.
      if (bus.issue_valid && bus.issue_rd != 5'd0) busy_d[bus.issue_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         write_e_q <= 1'b0;
         rd_q      <= 5'd0;
         write_d_q <= 32'd0;
         busy_q    <= 32'd0;
      end else begin
         write_e_q <= accept && (sel_rd != 5'd0);
         // x0 accepts consume the grant but leave the write port untouched.
         if (accept && sel_rd != 5'd0) begin
            rd_q      <= sel_rd;
            write_d_q <= sel_data;
         end
         busy_q <= busy_d;
      end
   end

   assign bus.alu_ready = alu_gnt;
   assign bus.lsu_ready = lsu_gnt;
   assign bus.hazard1   = busy_q[bus.rs1];
   assign bus.hazard2   = busy_q[bus.rs2];
   assign bus.write_e   = write_e_q;
   assign bus.rd        = rd_q;
   assign bus.write_d   = write_d_q;
endmodule
